adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares a single registered WIDTH-bit adder core between NREQ requesters. Each requester offers one operand set (a, b, cin) through a valid/ready handshake. The block grants one requester per cycle, feeds its operands through a two-stage flopped adder pipeline, and returns the sum tagged with the requester index. It sits between client datapaths and the team's adder core. It is the standard way to time-share one adder implementation instead of replicating it.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits
- NREQ, 4, number of requesters (≥1)
- IDW, $clog2(NREQ) with a minimum of 1, width of the requester index (derived; do not override)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept; one-hot or zero
- req_a  input  NREQ×WIDTH  packed operand A, one slice per requester
- req_b  input  NREQ×WIDTH  packed operand B, one slice per requester
- req_cin  input  NREQ  carry-in, one bit per requester
- rsp_valid  output  1  result valid
- rsp_ready  input  1  downstream accepts result
- rsp_id  output  IDW  index of the requester that owns the result
- rsp_s  output  WIDTH  sum
- rsp_cout  output  1  carry-out

## Operation
- Stage 1 (S1) register captures the granted requester's a, b, cin and id, plus s1_valid.
- The adder core sits combinationally between S1 and stage 2 (S2). S2 registers s, cout, id and rsp_valid; these drive the rsp_* outputs directly.
- Advance rules:
  - s2_en = !rsp_valid || rsp_ready
  - s1_en = !s1_valid || s2_en
  - S2 loads S1 contents (including s1_valid) when s2_en.
- Grant: among the requesters with req_valid high, pick one per the arbitration policy (see Configuration).
  - req_ready[g] = grant[g] & s1_en & !rst.
  - Transfer occurs when req_valid[i] & req_ready[i].
- req_ready may depend combinationally on req_valid and rsp_ready. Requesters must hold valid and data stable until the transfer and must not make valid depend on ready.
- Arithmetic: {rsp_cout, rsp_s} = a + b + cin, computed exactly in WIDTH+1 bits.
- A pending request that is never granted holds; it is never dropped.
- Reset values: rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, req_ready=0, s1_valid=0, round-robin pointer=0.
- Reset mid-operation discards all in-flight operations without producing a response.

## Timing
- Latency: a transfer in cycle t gives rsp_valid=1 in cycle t+2 when there is no backpressure.
- Throughput: one operation per cycle sustained, including back-to-back from the same requester.
- Backpressure: while rsp_valid && !rsp_ready, rsp_* stay stable.
  - S1 keeps loading only while it is empty.
  - Once both stages are full, req_ready is all-zero.
- Simultaneous rsp_ready and a new grant in the same cycle: S2 takes S1 and S1 takes the new request. There is no bubble.
- Idle: no req_valid gives no transfer, and the pointer does not move.

## Configuration
- ADDER_ARB_RR_EN defined: round-robin arbitration.
  - The pointer holds the index after the last granted requester and updates only on a transfer.
  - Search starts at the pointer and wraps from NREQ-1 to 0.
  - Any continuously requesting client is served within NREQ transfers.
- ADDER_ARB_RR_EN undefined: fixed priority, lowest index wins.
  - No pointer register exists.
  - Higher indices can starve.

## Structure
- Shared package adder_arb_pkg holds:
  - the IDW computation function (clog2 with a minimum of 1)
  - the S1 payload struct typedef {a, b, cin, id}
  - the S2 payload struct typedef {s, cout, id}
- One sub-module, adder_arb_pick: NREQ request vector plus pointer in, one-hot grant and encoded index out. It is purely combinational; the pointer register lives in adder_arbiter.
- The adder core is instantiated through the team's standard `ADDER_NAME selection with .WIDTH(WIDTH), ports a, b, cin, s, cout.

## Test plan
- Single request: NREQ=4, WIDTH=8, req 2 offers a=0xF0, b=0x20, cin=1 at cycle 5 -> rsp_valid at cycle 7 with rsp_id=2, rsp_s=0x11, rsp_cout=1.
- Wrap/extremes: a=0xFF, b=0x00, cin=1 -> s=0x00, cout=1. a=0, b=0, cin=0 -> s=0, cout=0.
- All four requesters continuously valid, RR enabled -> grant order 0,1,2,3,0,… and one rsp per cycle. Same stimulus without the macro -> always id 0.
- Backpressure: hold rsp_ready=0 for 5 cycles with requests pending -> at most 2 ops in flight, req_ready=0 once full, rsp_* stable. On release, results arrive in accept order with no loss or duplication.
- Reset mid-stream: assert rst with both stages full -> rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, req_ready=0 immediately. After deassert, the first grant goes to the lowest valid index and no stale response appears.
- Random scoreboard: 10k random operands with random valid/ready -> every result matches a+b+cin for its id, and per-requester order is preserved.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder_arbiter slice.
//   adder_arb_idw  - requester index width (clog2 with a minimum of 1)
//   adder_arb_s1_t - stage-1 payload {a, b, cin, id}
//   adder_arb_s2_t - stage-2 payload {s, cout, id}
// Payload fields are sized for the widest supported configuration
// (WIDTH <= ADDER_ARB_MAX_WIDTH, NREQ <= 2**ADDER_ARB_MAX_IDW). Users
// store their value in the low bits and leave the rest zero.
package adder_arb_pkg;

    localparam int unsigned ADDER_ARB_MAX_WIDTH = 64;
    localparam int unsigned ADDER_ARB_MAX_IDW   = 8;

    function automatic int unsigned adder_arb_idw(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    typedef struct packed {
        logic [ADDER_ARB_MAX_WIDTH-1:0] a;
        logic [ADDER_ARB_MAX_WIDTH-1:0] b;
        logic                           cin;
        logic [ADDER_ARB_MAX_IDW-1:0]   id;
    } adder_arb_s1_t;

    typedef struct packed {
        logic [ADDER_ARB_MAX_WIDTH-1:0] s;
        logic                           cout;
        logic [ADDER_ARB_MAX_IDW-1:0]   id;
    } adder_arb_s2_t;

endpackage

// File: rtl/adder_arb_core.sv
// adder_arb_core: default combinational adder core, {cout, s} = a + b + cin.
//   a, b - WIDTH-bit operands
//   cin  - carry-in
//   s    - WIDTH-bit sum
//   cout - carry-out
// Used by adder_arbiter when ADDER_NAME is not defined by the build.
module adder_arb_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_arb_pick.sv
// adder_arb_pick: combinational grant selection for adder_arbiter.
//   req   - per-requester valid vector
//   ptr   - round-robin start index (ignored in fixed-priority builds)
//   grant - one-hot grant, zero when no request
//   idx   - encoded index of the granted requester (0 when none)
// Macro ADDER_ARB_RR_EN selects round-robin from ptr with wrap; without
// it the lowest requesting index wins.
module adder_arb_pick
    import adder_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = adder_arb_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

`ifdef ADDER_ARB_RR_EN
    // Two ordered passes implement the wrap: first indices at or above the
    // pointer, then the lowest requester below it.
    always_comb begin
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = IDW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: time-shares one adder core between NREQ requesters.
// Granted operands are captured in S1, added combinationally, and the
// result is registered in S2, which drives rsp_* directly (latency 2).
//   clk, rst   - clock, asynchronous active-high reset
//   req_valid  - per-requester operand valid
//   req_ready  - per-requester accept (one-hot or zero)
//   req_a/b    - packed operands, WIDTH bits per requester
//   req_cin    - per-requester carry-in
//   rsp_valid  - result valid; rsp_ready - downstream accept
//   rsp_id     - owning requester index; rsp_s/rsp_cout - sum, carry-out
// Macros: ADDER_ARB_RR_EN enables round-robin arbitration (otherwise
// fixed priority, lowest index wins); ADDER_NAME selects the adder core
// module (default adder_arb_core).
`ifndef ADDER_NAME
`define ADDER_NAME adder_arb_core
`endif

module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDW   = adder_arb_idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [WIDTH-1:0]  rsp_s,
    output logic              rsp_cout
);

    logic            s1_valid;
    logic            s2_valid;
    adder_arb_s1_t   s1_q;
    adder_arb_s1_t   s1_d;
    adder_arb_s2_t   s2_q;
    adder_arb_s2_t   s2_d;
    logic            s1_en;
    logic            s2_en;
    logic            xfer;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  rr_ptr;
    logic [WIDTH-1:0] sum;
    logic            sum_cout;

    assign s2_en     = !s2_valid || rsp_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign req_ready = grant & {NREQ{s1_en & ~rst}};
    assign xfer      = |(req_valid & req_ready);

    adder_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

`ifdef ADDER_ARB_RR_EN
    // Pointer holds the index after the last granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    assign rr_ptr = '0;
`endif

    // Grant is one-hot, so OR-ing the masked slices is the operand mux.
    always_comb begin
        s1_d = '0;
        s1_d.id[IDW-1:0] = grant_idx;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                s1_d.a[WIDTH-1:0] = s1_d.a[WIDTH-1:0] | req_a[i*WIDTH +: WIDTH];
                s1_d.b[WIDTH-1:0] = s1_d.b[WIDTH-1:0] | req_b[i*WIDTH +: WIDTH];
                s1_d.cin          = s1_d.cin | req_cin[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_en) begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_q <= s1_d;
            end
        end
    end

    `ADDER_NAME #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (s1_q.a[WIDTH-1:0]),
        .b    (s1_q.b[WIDTH-1:0]),
        .cin  (s1_q.cin),
        .s    (sum),
        .cout (sum_cout)
    );

    always_comb begin
        s2_d = '0;
        s2_d.s[WIDTH-1:0] = sum;
        s2_d.cout         = sum_cout;
        s2_d.id           = s1_q.id;
    end

    // S2 payload only changes when a real result moves in, so rsp_* stay
    // put across bubbles as well as under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_q.id[IDW-1:0];
    assign rsp_s     = s2_q.s[WIDTH-1:0];
    assign rsp_cout  = s2_q.cout;

    // Padding bits above WIDTH/IDW are always zero.
    logic unused_pad;
    assign unused_pad = ^{s1_q.a, s1_q.b, s2_q.s, s2_q.id};

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_s;
    logic             rsp_cout;

    adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  s;
        logic          cout;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] seen_ids[$];
    bit            recording;
    int            errors = 0;
    int            checks = 0;
    bit            m_s1v;
    bit            m_s2v;
    int            m_ptr;
    logic [N-1:0]  last_xfer;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input int ptr);
        logic [N-1:0] g;
        g = '0;
`ifdef ADDER_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (g == '0 && v[j]) g[j] = 1'b1;
        end
`else
        for (int j = 0; j < N; j++) begin
            if (g == '0 && v[j] && ptr >= 0) g[j] = 1'b1;
        end
`endif
        return g;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
    endtask

    task automatic model_reset();
        m_s1v = 1'b0;
        m_s2v = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    // One clock: check at negedge, model advance at posedge, return #1 later.
    task automatic cycle();
        logic [N-1:0] g;
        logic [N-1:0] exp_rdy;
        bit           s2en, s1en, xfer;
        int           gi;
        exp_t         e;
        logic [W:0]   full;
        @(negedge clk);
        s2en    = !m_s2v || rsp_ready;
        s1en    = !m_s1v || s2en;
        g       = model_grant(req_valid, m_ptr);
        exp_rdy = (s1en && !rst) ? g : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_s2v));
        if (m_s2v && rsp_ready) begin
            chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_s", 64'(rsp_s), 64'(e.s));
                chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                if (recording) seen_ids.push_back(rsp_id);
            end
        end
        gi = 0;
        for (int i = 0; i < N; i++) if (g[i]) gi = i;
        xfer = (g != '0) && s1en && !rst;
        last_xfer = xfer ? g : '0;
        if (xfer) begin
            full = {1'b0, req_a[gi*W +: W]} + {1'b0, req_b[gi*W +: W]} + {{W{1'b0}}, req_cin[gi]};
            e.id   = IW'(gi);
            e.s    = full[W-1:0];
            e.cout = full[W];
            sb.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (s2en) m_s2v = m_s1v;
            if (s1en) m_s1v = xfer;
            if (xfer) m_ptr = (gi + 1) % N;
        end
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (req_valid == '0 && sb.size() == 0 && !m_s1v && !m_s2v) break;
            rsp_ready = 1'b1;
            cycle();
            req_valid = req_valid & ~last_xfer;
        end
        chk("drain_empty", 64'(sb.size()), 64'(0));
        chk("drain_valid", 64'(req_valid), 64'(0));
    endtask

    initial begin
        logic [IW-1:0] cap_id;
        logic [W-1:0]  cap_s;
        logic          cap_c;
        int            issued;
        int            cyc;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
        rsp_ready = 1'b1; recording = 1'b0; last_xfer = '0;
        model_reset();
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_s", 64'(rsp_s), 64'(0));
        chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        cycle(); cycle();
        rst = 1'b0;

        // Single request at cycle 5, response two cycles later.
        for (int k = 0; k < 5; k++) cycle();
        set_req(2, 8'hF0, 8'h20, 1'b1);
        cycle();
        chk("single_xfer", 64'(last_xfer), 64'(4'b0100));
        req_valid = '0;
        chk("lat_t1_valid", 64'(rsp_valid), 64'(0));
        cycle();
        chk("lat_t2_valid", 64'(rsp_valid), 64'(1));
        chk("lat_t2_id", 64'(rsp_id), 64'(2));
        chk("lat_t2_s", 64'(rsp_s), 64'(8'h11));
        chk("lat_t2_cout", 64'(rsp_cout), 64'(1));
        drain();

        // Operand extremes, two requesters at once.
        set_req(1, 8'hFF, 8'h00, 1'b1);
        set_req(3, 8'h00, 8'h00, 1'b0);
        drain();
        set_req(0, 8'hFF, 8'hFF, 1'b1);
        drain();

        // Backpressure: five cycles with rsp_ready low and all requesters pending.
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        rsp_ready = 1'b0;
        cap_id = '0; cap_s = '0; cap_c = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            req_valid = req_valid & ~last_xfer;
            if (k == 2) begin
                cap_id = rsp_id; cap_s = rsp_s; cap_c = rsp_cout;
                chk("bp_full_ready", 64'(req_ready), 64'(0));
            end else if (k > 2) begin
                chk("bp_stable_id", 64'(rsp_id), 64'(cap_id));
                chk("bp_stable_s", 64'(rsp_s), 64'(cap_s));
                chk("bp_stable_cout", 64'(rsp_cout), 64'(cap_c));
            end
        end
        drain();

        // Reset with both stages full.
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            req_valid = req_valid & ~last_xfer;
        end
        rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("mid_rst_rsp_s", 64'(rsp_s), 64'(0));
        chk("mid_rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
        cycle();
        rst = 1'b0;
        req_valid = '0;
        set_req(1, 8'h12, 8'h34, 1'b0);
        set_req(3, 8'h56, 8'h78, 1'b1);
        rsp_ready = 1'b1;
        cycle();
        chk("post_rst_grant", 64'(last_xfer), 64'(4'b0010));
        req_valid = req_valid & ~last_xfer;
        drain();

        // All requesters continuously valid from a fresh pointer.
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        seen_ids.delete();
        recording = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            for (int i = 0; i < N; i++)
                if (last_xfer[i]) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        end
        recording = 1'b0;
        chk("allv_count", 64'(seen_ids.size() >= 8), 64'(1));
        for (int k = 0; k < 8 && k < seen_ids.size(); k++) begin
`ifdef ADDER_ARB_RR_EN
            chk("allv_order", 64'(seen_ids[k]), 64'(k % N));
`else
            chk("allv_order", 64'(seen_ids[k]), 64'(0));
`endif
        end
        req_valid = '0;
        drain();

        // Random operands with random valid/ready.
        issued = 0;
        cyc = 0;
        while ((issued < 10000 || req_valid != '0) && cyc < 60000) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && issued < 10000 && $urandom_range(0, 2) != 0) begin
                    set_req(i, W'($urandom), W'($urandom), 1'($urandom));
                    issued++;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            req_valid = req_valid & ~last_xfer;
            cyc++;
        end
        chk("rand_done", 64'(issued >= 10000 && req_valid == '0), 64'(1));
        req_valid = '0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
